// File: rtl/snake_pkg.sv
// Shared definitions for the snake game sequencer: mode codes, direction
// codes and the scheduler state encoding.
package snake_pkg;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_PLAY = 2'b01;
  localparam logic [1:0] MODE_LOST = 2'b10;
  localparam logic [1:0] MODE_WON  = 2'b11;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_STEP,
    S_EVAL,
    S_LOST,
    S_WON
  } state_e;

  // Opposite pairs differ only in the LSB (up/down, left/right).
  function automatic logic [1:0] opposite_dir(input logic [1:0] dir);
    return {dir[1], ~dir[0]};
  endfunction

endpackage

// File: rtl/snake_step_scheduler_move_timer.sv
// Movement timebase: counts 0..period-1 while enabled and pulses tick_o on
// the terminal count. The period shrinks with score and floors at SPEED_STEP.
module move_timer
  import snake_pkg::*;
#(
  parameter int TICK_DIV   = 25_000_000,
  parameter int SPEED_STEP = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic [3:0] score_i,
  output logic       tick_o
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [31:0]      reduction;
  logic [31:0]      period;
  logic [CNT_W-1:0] last_cnt;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Score-dependent period and the next counter value.
  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    reduction = 32'(score_i) * 32'(SPEED_STEP);
    if (reduction + 32'(SPEED_STEP) >= 32'(TICK_DIV)) begin
      period = 32'(SPEED_STEP);
    end else begin
      period = 32'(TICK_DIV) - reduction;
    end
    last_cnt = CNT_W'(period - 32'd1);
    tick_o   = en_i && (cnt_q == last_cnt);
    cnt_d    = tick_o ? '0 : cnt_q + 1'b1;
  end

  // Counter register; restarts from zero on a new game and after each tick,
  // and holds while the step handshake is in progress.
  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/snake_step_scheduler.sv
// Game sequencer: play/lose/win mode machine, score, direction buffer and
// the req/ack step handshake towards the snake body datapath.
module snake_step_scheduler
  import snake_pkg::*;
#(
  parameter int TICK_DIV   = 25_000_000,
  parameter int SPEED_STEP = 1_000_000,
  parameter int WIN_SCORE  = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_mid,
  output logic       step_req,
  output logic [1:0] step_dir,
  input  logic       step_ack,
  input  logic       ate,
  input  logic       collide,
  output logic       clear,
  output logic [1:0] mode,
  output logic [3:0] score
);

  state_e     state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [3:0] score_q, score_d;
  logic       step_req_q, step_req_d;
  logic [1:0] step_dir_q, step_dir_d;
  logic [1:0] next_dir_q, next_dir_d;
  logic       clear_q, clear_d;
  logic       ate_q, ate_d;
  logic       collide_q, collide_d;

  logic       timer_clr;
  logic       timer_tick;
  logic       arrow_valid;
  logic [1:0] arrow_dir;
  logic [3:0] score_inc;

  move_timer #(
    .TICK_DIV  (TICK_DIV),
    .SPEED_STEP(SPEED_STEP)
  ) u_move_timer (
    .clk    (clk),
    .rst_i  (rst),
    .en_i   (state_q == S_WAIT_TICK),
    .clr_i  (timer_clr),
    .score_i(score_q),
    .tick_o (timer_tick)
  );

  // Next-state logic: arrow capture, mode machine, score and output decode.
  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    step_dir_d = step_dir_q;
    next_dir_d = next_dir_q;
    ate_d      = ate_q;
    collide_d  = collide_q;
    clear_d    = 1'b0;
    timer_clr  = 1'b0;

    // Simultaneous arrows resolve up > down > left > right.
    arrow_valid = btn_up | btn_down | btn_left | btn_right;
    if (btn_up) begin
      arrow_dir = DIR_UP;
    end else if (btn_down) begin
      arrow_dir = DIR_DOWN;
    end else if (btn_left) begin
      arrow_dir = DIR_LEFT;
    end else begin
      arrow_dir = DIR_RIGHT;
    end
    if (arrow_valid && (arrow_dir != opposite_dir(step_dir_q))) begin
      next_dir_d = arrow_dir;
    end

    score_inc = (score_q == 4'hF) ? score_q : score_q + 4'd1;

    case (state_q)
      S_IDLE, S_LOST, S_WON: begin
        if (btn_mid) begin
          clear_d    = 1'b1;
          score_d    = 4'd0;
          step_dir_d = DIR_RIGHT;
          next_dir_d = DIR_RIGHT;
          timer_clr  = 1'b1;
          state_d    = S_WAIT_TICK;
        end
      end
      S_WAIT_TICK: begin
        if (timer_tick) begin
          step_dir_d = next_dir_q;
          state_d    = S_STEP;
        end
      end
      S_STEP: begin
        if (step_ack) begin
          ate_d     = ate;
          collide_d = collide;
          state_d   = S_EVAL;
        end
      end
      S_EVAL: begin
        if (collide_q) begin
          state_d = S_LOST;
        end else if (ate_q) begin
          score_d = score_inc;
          state_d = (score_inc == 4'(WIN_SCORE)) ? S_WON : S_WAIT_TICK;
        end else begin
          state_d = S_WAIT_TICK;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_IDLE:  mode_d = MODE_IDLE;
      S_LOST:  mode_d = MODE_LOST;
      S_WON:   mode_d = MODE_WON;
      default: mode_d = MODE_PLAY;
    endcase
    step_req_d = (state_d == S_STEP);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= MODE_IDLE;
      score_q    <= 4'd0;
      step_req_q <= 1'b0;
      step_dir_q <= DIR_RIGHT;
      next_dir_q <= DIR_RIGHT;
      clear_q    <= 1'b0;
      ate_q      <= 1'b0;
      collide_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      score_q    <= score_d;
      step_req_q <= step_req_d;
      step_dir_q <= step_dir_d;
      next_dir_q <= next_dir_d;
      clear_q    <= clear_d;
      ate_q      <= ate_d;
      collide_q  <= collide_d;
    end
  end

  assign step_req = step_req_q;
  assign step_dir = step_dir_q;
  assign clear    = clear_q;
  assign mode     = mode_q;
  assign score    = score_q;

endmodule

// File: tb/tb_snake_step_scheduler.sv
// Directed bench for snake_step_scheduler with TICK_DIV=10, SPEED_STEP=2,
// WIN_SCORE=13, so the move period is max(10 - 2*score, 2) cycles.
module tb_snake_step_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
  logic       btn_right = 1'b0, btn_mid = 1'b0;
  logic       step_req;
  logic [1:0] step_dir;
  logic       step_ack = 1'b0, ate = 1'b0, collide = 1'b0;
  logic       clear;
  logic [1:0] mode;
  logic [3:0] score;

  int checks = 0;
  int errors = 0;

  snake_step_scheduler #(
    .TICK_DIV  (10),
    .SPEED_STEP(2),
    .WIN_SCORE (13)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .btn_mid  (btn_mid),
    .step_req (step_req),
    .step_dir (step_dir),
    .step_ack (step_ack),
    .ate      (ate),
    .collide  (collide),
    .clear    (clear),
    .mode     (mode),
    .score    (score)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Ticks until step_req is high, bounded; returns the number of ticks taken.
  task automatic wait_req(output int n);
    n = 0;
    while (!step_req && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic start_game();
    btn_mid = 1'b1;
    tick();
    btn_mid = 1'b0;
    check("start_clear", 32'(clear), 1);
    check("start_mode", 32'(mode), 1);
    check("start_score", 32'(score), 0);
    tick();
    check("clear_one_cycle", 32'(clear), 0);
  endtask

  task automatic do_ack(input logic a, input logic c);
    step_ack = 1'b1;
    ate      = a;
    collide  = c;
    tick();
    step_ack = 1'b0;
    ate      = 1'b0;
    collide  = 1'b0;
    check("req_drop_after_ack", 32'(step_req), 0);
    tick();
  endtask

  task automatic pulse_arrow(input logic u, input logic d, input logic l, input logic r);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    tick();
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int exp_period;

    // Reset state
    tick();
    tick();
    check("rst_mode", 32'(mode), 0);
    check("rst_score", 32'(score), 0);
    check("rst_req", 32'(step_req), 0);
    check("rst_dir", 32'(step_dir), 3);
    check("rst_clear", 32'(clear), 0);
    rst = 1'b0;
    tick();

    // Start and first step: req 10 cycles after the clear cycle
    start_game();
    wait_req(n);
    check("first_period", 32'(n), 9);
    check("first_dir", 32'(step_dir), 3);

    // Reversal: left while moving right is ignored
    pulse_arrow(1'b0, 1'b0, 1'b1, 1'b0);
    do_ack(1'b0, 1'b0);
    check("noeat_score", 32'(score), 0);
    check("noeat_mode", 32'(mode), 1);
    wait_req(n);
    check("period_s0", 32'(n), 10);
    check("left_ignored_dir", 32'(step_dir), 3);

    // Up and down together: up wins
    pulse_arrow(1'b1, 1'b1, 1'b0, 1'b0);
    do_ack(1'b0, 1'b0);
    wait_req(n);
    check("updown_dir", 32'(step_dir), 0);

    // Down while moving up is ignored
    pulse_arrow(1'b0, 1'b1, 1'b0, 1'b0);
    do_ack(1'b0, 1'b0);
    wait_req(n);
    check("down_ignored_dir", 32'(step_dir), 0);

    // Right while moving up is accepted
    pulse_arrow(1'b0, 1'b0, 1'b0, 1'b1);
    do_ack(1'b0, 1'b0);
    wait_req(n);
    check("right_dir", 32'(step_dir), 3);

    // Speed-up: eat up to score 12, checking the period each time
    for (int s = 1; s <= 12; s++) begin
      do_ack(1'b1, 1'b0);
      check("eat_score", 32'(score), 32'(s));
      check("eat_mode", 32'(mode), 1);
      exp_period = (10 - 2 * s > 2) ? 10 - 2 * s : 2;
      wait_req(n);
      check("speed_period", 32'(n), 32'(exp_period));
      if (s == 3) begin
        btn_mid = 1'b1;
        tick();
        btn_mid = 1'b0;
        check("mid_in_step_clear", 32'(clear), 0);
        check("mid_in_step_req", 32'(step_req), 1);
      end
    end

    // Win at score 13
    do_ack(1'b1, 1'b0);
    check("win_score", 32'(score), 13);
    check("win_mode", 32'(mode), 3);
    check("win_req", 32'(step_req), 0);
    step_ack = 1'b1;
    ate      = 1'b1;
    tick();
    step_ack = 1'b0;
    ate      = 1'b0;
    tick();
    check("win_ack_ignored_score", 32'(score), 13);
    check("win_req_stays_low", 32'(step_req), 0);

    // Restart from WON, then lose with ate+collide together
    start_game();
    wait_req(n);
    check("restart_period", 32'(n), 9);
    do_ack(1'b1, 1'b0);
    check("restart_eat_score", 32'(score), 1);
    wait_req(n);
    check("restart_period_s1", 32'(n), 8);
    do_ack(1'b1, 1'b1);
    check("lose_mode", 32'(mode), 2);
    check("lose_score", 32'(score), 1);
    tick();
    check("lose_req", 32'(step_req), 0);
    check("lose_mode_hold", 32'(mode), 2);

    // Restart from LOST, then stall the handshake and reset mid-step
    start_game();
    wait_req(n);
    check("restart2_period", 32'(n), 9);
    do_ack(1'b1, 1'b0);
    wait_req(n);
    check("restart2_period_s1", 32'(n), 8);
    btn_up = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      btn_up = 1'b0;
      check("stall_req", 32'(step_req), 1);
      check("stall_dir", 32'(step_dir), 3);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_req", 32'(step_req), 0);
    check("midrst_mode", 32'(mode), 0);
    check("midrst_score", 32'(score), 0);
    check("midrst_clear", 32'(clear), 0);

    // Restart after reset
    start_game();
    wait_req(n);
    check("postrst_period", 32'(n), 9);
    check("postrst_dir", 32'(step_dir), 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
